// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter handing one UART transmitter to one message source at a time.
// Optional ownership watchdog with sticky timeout_flag: define UART_ARB_WATCHDOG_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQUESTERS  = 4,
    parameter int IDLE_GAP_CLOCKS = 16,
    parameter int TIMEOUT_CLOCKS  = 100000,
    localparam int IW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_REQUESTERS-1:0]   request,
    output logic [NUM_REQUESTERS-1:0]   grant,
    output logic [IW-1:0]               owner_index,
    input  logic [NUM_REQUESTERS-1:0]   req_valid,
    input  logic [8*NUM_REQUESTERS-1:0] req_data,
    output logic [NUM_REQUESTERS-1:0]   req_active,
    output logic                        serial_output_valid,
    output logic [7:0]                  serial_output_data,
`ifdef UART_ARB_WATCHDOG_EN
    output logic                        timeout_flag,
`endif
    input  logic                        serial_output_active
);
    localparam int GW = (IDLE_GAP_CLOCKS > 0) ? $clog2(IDLE_GAP_CLOCKS + 1) : 1;

    if (NUM_REQUESTERS < 2 || NUM_REQUESTERS > 8) begin : g_bad_num
        $error("uart_tx_arbiter: NUM_REQUESTERS must be 2..8");
    end
    if (IDLE_GAP_CLOCKS < 0 || TIMEOUT_CLOCKS < 1) begin : g_bad_timing
        $error("uart_tx_arbiter: IDLE_GAP_CLOCKS must be >= 0 and TIMEOUT_CLOCKS >= 1");
    end

    typedef enum logic [1:0] {IDLE, GRANTED, DRAIN, GAP} state_t;

    state_t                    state_q, state_d;
    logic [NUM_REQUESTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]             owner_q, owner_d;
    logic [IW-1:0]             ptr_q, ptr_d;
    logic [GW-1:0]             gap_q, gap_d;
    logic                      out_valid_q, out_valid_d;
    logic [7:0]                out_data_q, out_data_d;
    logic [NUM_REQUESTERS-1:0] eligible;
    logic                      sel_found;
    logic [IW-1:0]             sel_idx;
    logic                      accept;
    logic                      drop;
    logic [7:0]                data_arr [NUM_REQUESTERS];

`ifdef UART_ARB_WATCHDOG_EN
    localparam int WW = (TIMEOUT_CLOCKS > 1) ? $clog2(TIMEOUT_CLOCKS) : 1;
    logic [WW-1:0]             wd_q, wd_d;
    logic                      timeout_q, timeout_d;
    logic [NUM_REQUESTERS-1:0] blocked_q, blocked_d;

    assign eligible     = request & ~blocked_q;
    assign timeout_flag = timeout_q;
`else
    assign eligible = request;
`endif

    // Owner sees busy during its launch cycle, before the UART raises active.
    for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_req
        assign req_active[gi] = grant_q[gi] ? (serial_output_active | out_valid_q) : 1'b1;
        assign data_arr[gi]   = req_data[8*gi +: 8];
    end

    always_comb begin
        logic [IW-1:0] cand;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            cand = IW'((int'(ptr_q) + k) % NUM_REQUESTERS);
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        gap_d       = gap_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        accept      = 1'b0;
        drop        = 1'b0;
`ifdef UART_ARB_WATCHDOG_EN
        wd_d        = wd_q;
        timeout_d   = timeout_q;
        blocked_d   = blocked_q & request;
`endif
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d = NUM_REQUESTERS'(1) << sel_idx;
                    owner_d = sel_idx;
                    state_d = GRANTED;
`ifdef UART_ARB_WATCHDOG_EN
                    wd_d    = '0;
`endif
                end
            end
            GRANTED: begin
                accept = req_valid[owner_q] & request[owner_q] & ~serial_output_active & ~out_valid_q;
                if (!request[owner_q]) begin
                    drop = 1'b1;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = data_arr[owner_q];
`ifdef UART_ARB_WATCHDOG_EN
                    wd_d        = '0;
`endif
                end
`ifdef UART_ARB_WATCHDOG_EN
                else if (wd_q == WW'(TIMEOUT_CLOCKS - 1)) begin
                    drop               = 1'b1;
                    timeout_d          = 1'b1;
                    blocked_d[owner_q] = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            DRAIN: begin
                if (!serial_output_active && !out_valid_q) begin
                    if (IDLE_GAP_CLOCKS == 0) begin
                        state_d = IDLE;
                    end else begin
                        gap_d   = GW'(IDLE_GAP_CLOCKS);
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                gap_d = gap_q - 1'b1;
                if (gap_q <= GW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Releasing the owner moves the pointer past it so others go first.
        if (drop) begin
            grant_d = '0;
            ptr_d   = (owner_q == IW'(NUM_REQUESTERS - 1)) ? '0 : owner_q + 1'b1;
            state_d = DRAIN;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            ptr_q       <= '0;
            gap_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef UART_ARB_WATCHDOG_EN
            wd_q        <= '0;
            timeout_q   <= 1'b0;
            blocked_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            gap_q       <= gap_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef UART_ARB_WATCHDOG_EN
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
            blocked_q   <= blocked_d;
`endif
        end
    end

    assign grant               = grant_q;
    assign owner_index         = owner_q;
    assign serial_output_valid = out_valid_q;
    assign serial_output_data  = out_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: behavioural UART stub plus round-robin
// ownership model; watchdog scenario runs when UART_ARB_WATCHDOG_EN is defined.
module tb_uart_tx_arbiter;
    localparam int N         = 4;
    localparam int GAP       = 16;
    localparam int TO        = 50;
    localparam int UART_CLKS = 12;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   request = '0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   grant;
    logic [1:0]     owner_index;
    logic [N-1:0]   req_active;
    logic           serial_output_valid;
    logic [7:0]     serial_output_data;
    logic           serial_output_active;
`ifdef UART_ARB_WATCHDOG_EN
    logic           timeout_flag;
`endif

    int asserts = 0;
    int fails   = 0;

    always #5 clock = ~clock;

    uart_tx_arbiter #(
        .NUM_REQUESTERS (N),
        .IDLE_GAP_CLOCKS(GAP),
        .TIMEOUT_CLOCKS (TO)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .request             (request),
        .grant               (grant),
        .owner_index         (owner_index),
        .req_valid           (req_valid),
        .req_data            (req_data),
        .req_active          (req_active),
        .serial_output_valid (serial_output_valid),
        .serial_output_data  (serial_output_data),
`ifdef UART_ARB_WATCHDOG_EN
        .timeout_flag        (timeout_flag),
`endif
        .serial_output_active(serial_output_active)
    );

    // UART stub: busy for UART_CLKS cycles after each strobe; never reset by the arbiter.
    int         uart_cnt = 0;
    logic [7:0] rx_byte [$];
    logic [1:0] rx_owner [$];
    always @(posedge clock) begin
        if (serial_output_valid) begin
            rx_byte.push_back(serial_output_data);
            rx_owner.push_back(owner_index);
            uart_cnt <= UART_CLKS;
        end else if (uart_cnt > 0) begin
            uart_cnt <= uart_cnt - 1;
        end
    end
    assign serial_output_active = (uart_cnt != 0);

    int   sov_no_grant = 0;
    int   sov_double   = 0;
    logic sov_prev     = 1'b0;
    always @(posedge clock) begin
        if (serial_output_valid && grant == '0) sov_no_grant <= sov_no_grant + 1;
        if (serial_output_valid && sov_prev)    sov_double   <= sov_double + 1;
        sov_prev <= serial_output_valid;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "global timeout");
    end

    function automatic int pick(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++)
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_uart_idle();
        int t = 0;
        while ((serial_output_active || serial_output_valid) && t < 200) begin
            tick();
            t++;
        end
    endtask

    task automatic do_reset();
        request   = '0;
        req_valid = '0;
        req_data  = '0;
        wait_uart_idle();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_grant(output int cyc);
        cyc = 0;
        while (grant == '0 && cyc < 300) begin
            tick();
            cyc++;
        end
        asserts++;
        if (grant == '0) begin
            fails++;
            $display("FAIL wait_grant: grant=%b after %0d cycles, required nonzero", grant, cyc);
        end
    endtask

    task automatic send_byte(input int o, input logic [7:0] b);
        int t = 0;
        while (req_active[o] && t < 300) begin
            tick();
            t++;
        end
        asserts++;
        if (req_active[o] !== 1'b0) begin
            fails++;
            $display("FAIL send_ready: req_active[%0d]=%b, required 0", o, req_active[o]);
        end
        req_valid[o]       = 1'b1;
        req_data[8*o +: 8] = b;
        tick();
        req_valid[o] = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        asserts++;
        if (grant !== '0 || owner_index !== 2'd0) begin
            fails++;
            $display("FAIL reset_grant: grant=%b owner=%0d, required 0000/0", grant, owner_index);
        end
        asserts++;
        if (serial_output_valid !== 1'b0 || serial_output_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_out: valid=%b data=%h, required 0/00", serial_output_valid, serial_output_data);
        end
        asserts++;
        if (req_active !== 4'b1111) begin
            fails++;
            $display("FAIL reset_active: req_active=%b, required 1111", req_active);
        end
        reset_n = 1'b1;
        tick();
        asserts++;
        if (grant !== '0) begin
            fails++;
            $display("FAIL reset_idle: grant=%b, required 0000", grant);
        end
`ifdef UART_ARB_WATCHDOG_EN
        asserts++;
        if (timeout_flag !== 1'b0) begin
            fails++;
            $display("FAIL reset_timeout_flag: got %b, required 0", timeout_flag);
        end
`endif
        $display("test_reset done");
    endtask

    task automatic test_single();
        int base, c;
        do_reset();
        base    = rx_byte.size();
        request = 4'b0010;
        tick();
        asserts++;
        if (grant !== 4'b0010 || owner_index !== 2'd1) begin
            fails++;
            $display("FAIL single_grant: grant=%b owner=%0d, required 0010/1", grant, owner_index);
        end
        send_byte(1, 8'h55);
        send_byte(1, 8'hA3);
        request = '0;
        tick();
        asserts++;
        if (grant !== 4'b0000) begin
            fails++;
            $display("FAIL single_release: grant=%b, required 0000", grant);
        end
        wait_uart_idle();
        request = 4'b0010;
        wait_grant(c);
        asserts++;
        if (c < GAP) begin
            fails++;
            $display("FAIL single_gap: regrant %0d clocks after idle, required >= %0d", c, GAP);
        end
        asserts++;
        if (rx_byte.size() != base + 2) begin
            fails++;
            $display("FAIL single_count: %0d bytes, required 2", rx_byte.size() - base);
        end else begin
            asserts++;
            if (rx_byte[base] !== 8'h55 || rx_byte[base+1] !== 8'hA3 || rx_owner[base] !== 2'd1) begin
                fails++;
                $display("FAIL single_bytes: got %h %h owner %0d, required 55 A3 owner 1",
                         rx_byte[base], rx_byte[base+1], rx_owner[base]);
            end
        end
        request = '0;
        $display("test_single done: regrant after %0d clocks", c);
    endtask

    task automatic test_contention();
        int         base, c, o, exp_ptr, bad;
        logic [N-1:0] expg;
        logic [7:0] b;
        logic [7:0] exp_byte [$];
        int         exp_own [$];
        do_reset();
        base    = rx_byte.size();
        exp_ptr = 0;
        request = '1;
        for (int m = 0; m < 5; m++) begin
            wait_grant(c);
            o    = pick(request, exp_ptr);
            expg = '0;
            expg[o] = 1'b1;
            asserts++;
            if (grant !== expg || owner_index !== 2'(o)) begin
                fails++;
                $display("FAIL contention_owner: msg %0d grant=%b owner=%0d, required %b/%0d",
                         m, grant, owner_index, expg, o);
            end
            for (int k = 0; k < 2; k++) begin
                b = 8'($urandom);
                send_byte(o, b);
                exp_byte.push_back(b);
                exp_own.push_back(o);
                repeat ($urandom_range(0, 3)) tick();
            end
            request[o] = 1'b0;
            tick();
            asserts++;
            if (grant !== '0) begin
                fails++;
                $display("FAIL contention_release: grant=%b, required 0000", grant);
            end
            request[o] = 1'b1;
            exp_ptr    = (o + 1) % N;
            $display("contention msg %0d: owner %0d", m, owner_index);
        end
        request = '0;
        wait_uart_idle();
        asserts++;
        if (rx_byte.size() != base + exp_byte.size()) begin
            fails++;
            $display("FAIL contention_count: %0d bytes, required %0d", rx_byte.size() - base, exp_byte.size());
        end else begin
            bad = 0;
            foreach (exp_byte[i])
                if (rx_byte[base+i] !== exp_byte[i] || rx_owner[base+i] !== 2'(exp_own[i])) bad++;
            asserts++;
            if (bad != 0) begin
                fails++;
                $display("FAIL contention_order: %0d bytes wrong or interleaved, required 0", bad);
            end
        end
        asserts++;
        if (sov_no_grant != 0 || sov_double != 0) begin
            fails++;
            $display("FAIL contention_strobe: %0d strobes without grant, %0d back-to-back, required 0/0",
                     sov_no_grant, sov_double);
        end
    endtask

    task automatic test_nonowner();
        int base, c, bad;
        do_reset();
        request = 4'b0001;
        wait_grant(c);
        asserts++;
        if (grant !== 4'b0001 || req_active[0] !== 1'b0) begin
            fails++;
            $display("FAIL nonowner_grant: grant=%b req_active=%b, required 0001 owner idle", grant, req_active);
        end
        base              = rx_byte.size();
        req_valid[2]      = 1'b1;
        req_data[23:16]   = 8'hFF;
        bad               = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            req_valid[2] = 1'b0;
            if (serial_output_valid !== 1'b0 || req_active[2] !== 1'b1) bad++;
        end
        asserts++;
        if (bad != 0 || rx_byte.size() != base) begin
            fails++;
            $display("FAIL nonowner_strobe: %0d bad cycles, %0d bytes sent, required 0/0", bad, rx_byte.size() - base);
        end
        request = '0;
        $display("test_nonowner done");
    endtask

    task automatic test_back_to_back();
        int         base, c, o, t, low;
        logic [7:0] b1, b2;
        do_reset();
        o       = $urandom_range(0, N - 1);
        b1      = 8'($urandom);
        b2      = ~b1;
        request = '0;
        request[o] = 1'b1;
        wait_grant(c);
        t = 0;
        while (req_active[o] && t < 100) begin
            tick();
            t++;
        end
        base               = rx_byte.size();
        req_valid[o]       = 1'b1;
        req_data[8*o +: 8] = b1;
        tick();
        asserts++;
        if (serial_output_valid !== 1'b1 || serial_output_data !== b1 || req_active[o] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_first: valid=%b data=%h active=%b, required 1/%h/1",
                     serial_output_valid, serial_output_data, req_active[o], b1);
        end
        req_data[8*o +: 8] = b2;
        tick();
        req_valid[o] = 1'b0;
        asserts++;
        if (serial_output_valid !== 1'b0 || req_active[o] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second: valid=%b active=%b, required 0/1", serial_output_valid, req_active[o]);
        end
        low = 0;
        t   = 0;
        while (serial_output_active && t < 100) begin
            if (req_active[o] !== 1'b1) low++;
            tick();
            t++;
        end
        asserts++;
        if (low != 0 || req_active[o] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_active: %0d low cycles while busy, final=%b, required 0/0", low, req_active[o]);
        end
        asserts++;
        if (rx_byte.size() != base + 1 || rx_byte[base] !== b1) begin
            fails++;
            $display("FAIL b2b_bytes: %0d bytes first=%h, required 1 byte %h", rx_byte.size() - base, rx_byte[base], b1);
        end
        request = '0;
        $display("test_back_to_back done: owner %0d byte %h", o, b1);
    endtask

    task automatic test_reset_mid();
        int c;
        do_reset();
        request = 4'b0100;
        wait_grant(c);
        send_byte(2, 8'($urandom));
        tick();
        tick();
        asserts++;
        if (owner_index !== 2'd2 || grant !== 4'b0100) begin
            fails++;
            $display("FAIL midreset_pre: grant=%b owner=%0d, required 0100/2", grant, owner_index);
        end
        #3;
        reset_n = 1'b0;
        #1;
        asserts++;
        if (grant !== '0 || serial_output_valid !== 1'b0 || owner_index !== 2'd0) begin
            fails++;
            $display("FAIL midreset_async: grant=%b valid=%b owner=%0d, required 0000/0/0",
                     grant, serial_output_valid, owner_index);
        end
        request = 4'b1000;
        #1;
        reset_n = 1'b1;
        tick();
        asserts++;
        if (grant !== 4'b1000 || owner_index !== 2'd3) begin
            fails++;
            $display("FAIL midreset_regrant: grant=%b owner=%0d, required 1000/3", grant, owner_index);
        end
        request = '0;
        $display("test_reset_mid done");
    endtask

`ifdef UART_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        int c, bad;
        do_reset();
        request = 4'b0110;
        tick();
        asserts++;
        if (grant !== 4'b0010) begin
            fails++;
            $display("FAIL wd_grant: grant=%b, required 0010", grant);
        end
        bad = 0;
        for (int k = 1; k < TO; k++) begin
            tick();
            if (grant !== 4'b0010) bad++;
        end
        tick();
        asserts++;
        if (bad != 0 || grant !== 4'b0000 || timeout_flag !== 1'b1) begin
            fails++;
            $display("FAIL wd_expire: %0d early drops, grant=%b flag=%b, required 0/0000/1", bad, grant, timeout_flag);
        end
        wait_grant(c);
        asserts++;
        if (grant !== 4'b0100) begin
            fails++;
            $display("FAIL wd_next: grant=%b, required 0100", grant);
        end
        request[2] = 1'b0;
        bad = 0;
        for (int k = 0; k < 3 * GAP + 10; k++) begin
            tick();
            if (grant !== '0) bad++;
        end
        asserts++;
        if (bad != 0) begin
            fails++;
            $display("FAIL wd_blocked: %0d cycles granted, required 0", bad);
        end
        request[1] = 1'b0;
        tick();
        request[1] = 1'b1;
        wait_grant(c);
        asserts++;
        if (grant !== 4'b0010 || timeout_flag !== 1'b1) begin
            fails++;
            $display("FAIL wd_toggle: grant=%b flag=%b, required 0010/1", grant, timeout_flag);
        end
        request = '0;
        $display("test_watchdog done");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_nonowner();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        wait_uart_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
